// File: rtl/rtos_leds_pkg.sv
// Shared constants and helpers for the RTOSLeds AXI4-Lite register file.
package rtos_leds_pkg;

    localparam int DATA_W   = 32;
    localparam int STRB_W   = DATA_W / 8;
    localparam int ADDR_LSB = 2;

    localparam logic [1:0] REG_LED_VAL      = 2'd0;
    localparam logic [1:0] REG_BLINK_MASK   = 2'd1;
    localparam logic [1:0] REG_BLINK_PERIOD = 2'd2;
    localparam logic [1:0] REG_SCRATCH      = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rtos_leds_blink_timer.sv
// Blink phase generator: phase toggles every `period_i` cycles; period 0 parks
// the phase high, and a restart pulse re-arms the counter with phase high.
module rtos_leds_blink_timer
    import rtos_leds_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] period_i,
    input  logic              restart_i,
    output logic              phase_o
);

    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (restart_i || period_i == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == period_i - 1'b1) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/rtos_leds_axil_slave.sv
// AXI4-Lite slave with four R/W registers driving blinking LEDs.
// Define RTOS_LEDS_PWM_EN to gate the LEDs with an 8-bit PWM duty from SCRATCH[7:0].
module rtos_leds_axil_slave
    import rtos_leds_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LED_W              = 4
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0]             s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [LED_W-1:0]              led_o
);

    logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] regs_q [4];
    logic [LED_W-1:0]  led_q, led_d;
    logic [1:0]        wr_idx, rd_idx;
    logic              wr_en, rd_en, phase, pwm_on;
    logic              unused_w;

    assign wr_idx = s_axi_awaddr[ADDR_LSB+1:ADDR_LSB];
    assign rd_idx = s_axi_araddr[ADDR_LSB+1:ADDR_LSB];
    // A transfer completes on the edge where both ready pulses meet their valids.
    assign wr_en  = awready_q & s_axi_awvalid & wready_q & s_axi_wvalid;
    assign rd_en  = arready_q & s_axi_arvalid;

    assign unused_w = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

    rtos_leds_blink_timer u_blink (
        .clk_i     (s00_axi_aclk),
        .rst_i     (s00_axi_areset),
        .period_i  (regs_q[REG_BLINK_PERIOD]),
        .restart_i (wr_en && wr_idx == REG_BLINK_PERIOD),
        .phase_o   (phase)
    );

`ifdef RTOS_LEDS_PWM_EN
    logic [7:0] pwm_cnt_q;

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) pwm_cnt_q <= '0;
        else                pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end

    assign pwm_on = pwm_cnt_q < regs_q[REG_SCRATCH][7:0];
`else
    assign pwm_on = 1'b1;
`endif

    assign led_d = regs_q[REG_LED_VAL][LED_W-1:0]
                 & (~regs_q[REG_BLINK_MASK][LED_W-1:0] | {LED_W{phase}})
                 & {LED_W{pwm_on}};

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            led_q     <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            awready_q <= s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
            wready_q  <= s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
            arready_q <= s_axi_arvalid & ~rvalid_q & ~arready_q;
            led_q     <= led_d;

            if (wr_en) begin
                regs_q[wr_idx] <= apply_wstrb(regs_q[wr_idx], s_axi_wdata, s_axi_wstrb);
                bvalid_q       <= 1'b1;
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            // Read samples pre-write contents when both land on the same edge.
            if (rd_en) begin
                rdata_q  <= regs_q[rd_idx];
                rvalid_q <= 1'b1;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign s_axi_rvalid  = rvalid_q;
    assign led_o         = led_q;

endmodule

// File: tb/tb_rtos_leds_axil_slave.sv
// Scoreboard bench for rtos_leds_axil_slave: expected responses queued at issue,
// popped and compared by a monitor whenever a B or R handshake completes.
module tb_rtos_leds_axil_slave;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
    logic        arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [3:0]  led;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_r[$];
    logic [1:0]  exp_b[$];
    logic [31:0] mon_r;
    logic [1:0]  mon_b;

    always #5 clk = ~clk;

    rtos_leds_axil_slave dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (areset),
        .s_axi_awaddr   (awaddr),
        .s_axi_awprot   (awprot),
        .s_axi_awvalid  (awvalid),
        .s_axi_awready  (awready),
        .s_axi_wdata    (wdata),
        .s_axi_wstrb    (wstrb),
        .s_axi_wvalid   (wvalid),
        .s_axi_wready   (wready),
        .s_axi_bresp    (bresp),
        .s_axi_bvalid   (bvalid),
        .s_axi_bready   (bready),
        .s_axi_araddr   (araddr),
        .s_axi_arprot   (arprot),
        .s_axi_arvalid  (arvalid),
        .s_axi_arready  (arready),
        .s_axi_rdata    (rdata),
        .s_axi_rresp    (rresp),
        .s_axi_rvalid   (rvalid),
        .s_axi_rready   (rready),
        .led_o          (led)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake did not complete within cycle budget", name);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit expect_resp);
        int n;
        if (expect_resp) exp_b.push_back(2'b00);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(awready && wready) && n < 20);
        if (!(awready && wready)) timeout("write_accept");
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (expect_resp) begin
            n = 0;
            while (bvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (bvalid) timeout("write_resp");
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp_data,
                            input bit expect_resp);
        int n;
        if (expect_resp) exp_r.push_back(exp_data);
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 20);
        if (!arready) timeout("read_accept");
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        if (expect_resp) begin
            n = 0;
            while (rvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (rvalid) timeout("read_resp");
        end
    endtask

    // Monitor: compares on the negedge preceding each completing handshake edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bvalid && bready && !areset) begin
                if (exp_b.size() == 0) begin
                    timeout("unexpected_bresp");
                end else begin
                    mon_b = exp_b.pop_front();
                    check("bresp", {30'd0, bresp}, {30'd0, mon_b});
                end
            end
            if (rvalid && rready && !areset) begin
                if (exp_r.size() == 0) begin
                    timeout("unexpected_rdata");
                end else begin
                    mon_r = exp_r.pop_front();
                    check("rdata", rdata, mon_r);
                    check("rresp", {30'd0, rresp}, 32'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;
        int bcount;
        int hi;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata,            32'd0);
        check("rst_led",     {28'd0, led},     32'd0);
        areset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full-width write/readback of all four registers.
        axi_write(4'h0, 32'h0101FFFF, 4'hF, 1);
        axi_write(4'h4, 32'hABCD0001, 4'hF, 1);
        axi_write(4'h8, 32'hDEAD0011, 4'hF, 1);
        axi_write(4'hC, 32'hBEEF0011, 4'hF, 1);
        axi_read(4'h0, 32'h0101FFFF, 1);
        axi_read(4'h4, 32'hABCD0001, 1);
        axi_read(4'h8, 32'hDEAD0011, 1);
        axi_read(4'hC, 32'hBEEF0011, 1);
        axi_read(4'h7, 32'hABCD0001, 1);

        // Byte strobes.
        axi_write(4'h0, 32'hFFFFFFFF, 4'hF, 1);
        axi_write(4'h0, 32'h000000A5, 4'h1, 1);
        axi_read(4'h0, 32'hFFFFFFA5, 1);
        axi_write(4'h0, 32'h12340000, 4'h0, 1);
        axi_read(4'h0, 32'hFFFFFFA5, 1);

        // AW three cycles ahead of W, response stalled five cycles.
        bready = 1'b0;
        exp_b.push_back(2'b00);
        awaddr  = 4'hC;
        wdata   = 32'h12345678;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        accepts = 0;
        repeat (3) begin
            @(negedge clk);
            if (awready || wready) accepts++;
        end
        check("aw_only_no_accept", accepts, 0);
        wvalid = 1'b1;
        hi = 0;
        do begin
            @(negedge clk);
            hi++;
        end while (!awready && hi < 20);
        if (awready) accepts++;
        else timeout("aw_first_accept");
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bcount  = 0;
        repeat (5) begin
            @(negedge clk);
            if (bvalid) bcount++;
            if (awready) accepts++;
        end
        check("bvalid_held", bcount, 5);
        check("single_accept", accepts, 1);
        @(posedge clk);
        #1;
        bready = 1'b1;
        repeat (3) @(negedge clk);
        check("bvalid_cleared", {31'd0, bvalid}, 32'd0);
        axi_read(4'hC, 32'h12345678, 1);

`ifndef RTOS_LEDS_PWM_EN
        // Blink: lanes 1:0 toggle every four cycles, lanes 3:2 steady.
        axi_write(4'h0, 32'h0000000F, 4'hF, 1);
        axi_write(4'h4, 32'h00000003, 4'hF, 1);
        axi_write(4'h8, 32'h00000004, 4'hF, 1);
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("blink_led_%0d", k), {28'd0, led},
                  (((k - 1) / 4) % 2 == 0) ? 32'hF : 32'hC);
        end
        axi_write(4'h8, 32'h00000000, 4'hF, 1);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("period0_led_%0d", k), {28'd0, led}, 32'hF);
        end
`else
        // PWM: duty 0x80 drives led_o[0] for 128 of every 256 cycles.
        axi_write(4'h0, 32'h00000001, 4'hF, 1);
        axi_write(4'h4, 32'h00000000, 4'hF, 1);
        axi_write(4'h8, 32'h00000000, 4'hF, 1);
        axi_write(4'hC, 32'h00000080, 4'hF, 1);
        axi_read(4'hC, 32'h00000080, 1);
        repeat (4) @(negedge clk);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            if (led[0]) hi++;
        end
        check("pwm_high_count", hi, 128);
        axi_write(4'h0, 32'h0000000F, 4'hF, 1);
        axi_write(4'hC, 32'h00000000, 4'hF, 1);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            if (led != 4'h0) hi++;
        end
        check("pwm_duty0_off", hi, 0);
        axi_write(4'h0, 32'h00000000, 4'hF, 1);
`endif

        // Reset in the middle of pending B and R responses.
        axi_write(4'h0, 32'h0000000F, 4'hF, 1);
        bready = 1'b0;
        rready = 1'b0;
        axi_write(4'hC, 32'h00000055, 4'hF, 0);
        axi_read(4'h0, 32'h0, 0);
        @(negedge clk);
        check("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        check("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
        check("pre_rst_rdata",  rdata, 32'h0000000F);
`ifndef RTOS_LEDS_PWM_EN
        check("pre_rst_led", {28'd0, led}, 32'hF);
`endif
        #2;
        areset = 1'b1;
        #1;
        check("async_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("async_rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("async_rst_led",    {28'd0, led},    32'd0);
        check("async_rst_rdata",  rdata,           32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        bready = 1'b1;
        rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        axi_read(4'h0, 32'h0, 1);
        axi_read(4'h4, 32'h0, 1);
        axi_read(4'h8, 32'h0, 1);
        axi_read(4'hC, 32'h0, 1);
        @(negedge clk);
        check("post_rst_led", {28'd0, led}, 32'd0);

        repeat (3) @(posedge clk);
        check("b_queue_drained", exp_b.size(), 0);
        check("r_queue_drained", exp_r.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtos_leds_axil_slave.md
Name: rtos_leds_axil_slave

Overview:
AXI4-Lite slave register file and LED driver for the RTOSLeds peripheral: the block the AXI4-Lite master (BFM in simulation, PS GP port on Zybo) writes and reads. It holds four 32-bit fully read/write registers at offsets 0x0/0x4/0x8/0xC and drives the board LEDs with optional per-bit blinking. The FreeRTOS LED task toggles LEDs through it.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 4, byte address width (4 registers)
LED_W, 4, number of LED outputs (LED_W <= 32)

Ports:
s00_axi_aclk  in  1  clock, all logic on rising edge
s00_axi_areset  in  1  asynchronous active-high reset
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid / s_axi_awready  in / out  1  write address handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid / s_axi_wready  in / out  1  write data handshake
s_axi_bresp  out  2  write response, always 2'b00 OKAY
s_axi_bvalid / s_axi_bready  out / in  1  write response handshake
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid / s_axi_arready  in / out  1  read address handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  always 2'b00 OKAY
s_axi_rvalid / s_axi_rready  out / in  1  read data handshake
led_o  out  LED_W  LED drive, active-high

Behaviour:
- Reset (async, active-high): all ready/valid outputs 0, rdata 0, REG0..REG3 = 0, blink counter 0, phase 1, led_o 0.
- Register map (addr[3:2]): 0 LED_VAL, 1 BLINK_MASK, 2 BLINK_PERIOD, 3 SCRATCH (3 = PWM duty when feature enabled); addr[1:0] ignored. All 32 bits store and read back exactly.
- Write: awready and wready pulse high together for one cycle when awvalid & wvalid & !bvalid & !awready. On that edge register updated per wstrb byte lanes (wstrb=0: no change). bvalid rises next cycle, held until bready; no new write accepted while bvalid=1. AW-before-W or W-before-AW: wait, no accept until both valid.
- Read: arready pulses one cycle when arvalid & !rvalid & !arready; rdata latched same edge, rvalid next cycle, held with stable rdata until rready.
- Write and read accepted on same edge to same register: read returns pre-write value.
- Write latency to register: 1 edge after handshake; led_o reflects new LED_VAL 1 cycle after that (registered output).
- Blink: counter increments each cycle; when counter == BLINK_PERIOD-1, counter <- 0 and phase toggles. BLINK_PERIOD == 0: counter held 0, phase held 1. Any write to BLINK_PERIOD resets counter 0, phase 1. Counter 32-bit, no wrap issue since compare precedes overflow.
- led_o[i] <= LED_VAL[i] & (~BLINK_MASK[i] | phase).
- Reset mid-transaction: handshakes abort immediately, no response issued for in-flight transfers.

Optional Feature:
RTOS_LEDS_PWM_EN: defined -> SCRATCH[7:0] is PWM duty D; free-running 8-bit counter c, led_o gated additionally by (c < D); D=0 -> LEDs off, D=255 -> on 255/256. SCRATCH still reads back all 32 bits. Undefined -> SCRATCH plain storage, no gating.

Decomposition:
- rtos_leds_pkg: register index constants (REG_LED_VAL=0, REG_BLINK_MASK=1, REG_BLINK_PERIOD=2, REG_SCRATCH=3), RESP_OKAY=2'b00, data width constant.
- One sub-module: rtos_leds_blink_timer (period in, restart pulse in, phase out).

Test Plan:
- Reset release, write 0x0101FFFF/0xabcd0001/0xdead0011/0xbeef0011 to 0x0/0x4/0x8/0xC, read each back -> identical data, bresp=rresp=OKAY.
- Write 0xFFFFFFFF to 0x0, then 0x000000A5 with wstrb=4'b0001 -> readback 0xFFFFFFA5.
- AWVALID 3 cycles before WVALID, BREADY low 5 cycles -> single accept when both valid, bvalid held 5 cycles, no second accept.
- LED_VAL=0xF, BLINK_MASK=0x3, BLINK_PERIOD=4 -> led_o[1:0] toggle every 4 cycles, led_o[3:2] steady 1; PERIOD=0 -> all steady 1.
- Assert s00_axi_areset while rvalid=1 -> rvalid, bvalid, led_o drop to 0 asynchronously, registers read 0 after release.
- With RTOS_LEDS_PWM_EN, SCRATCH=0x80, LED_VAL=0x1, no blink -> led_o[0] high 128 of every 256 cycles.
